imem_boot_loader: RTL and testbench

- Boot/program controller for the instruction ROM.
- Receives a framed byte stream (UART/debug bridge) and writes words into the ROM through its programming port.
- Holds the core's fetch path off while loading, then releases fetch once the image checksum verifies.
- Sits between the fetch unit, the byte source and the ROM; sole owner of the ROM's prog_en/imem_ren arbitration.

---
 rtl/imem_boot_loader_pkg.sv | 21 ++
 rtl/imem_boot_loader_if.sv | 12 +
 rtl/imem_boot_loader_word_assembler.sv | 71 +++++++
 rtl/imem_boot_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-ROM boot loader.
package imem_boot_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned COUNT_W        = 16;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;

    localparam logic [BYTE_W-1:0] BOOT_MAGIC = 8'hA5;

    typedef logic [2:0] boot_state_t;

    localparam boot_state_t ST_SYNC   = 3'd0;
    localparam boot_state_t ST_HDR_LO = 3'd1;
    localparam boot_state_t ST_HDR_HI = 3'd2;
    localparam boot_state_t ST_DATA   = 3'd3;
    localparam boot_state_t ST_CSUM   = 3'd4;
    localparam boot_state_t ST_RUN    = 3'd5;
    localparam boot_state_t ST_ERROR  = 3'd6;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake between the UART/debug bridge and the boot loader.
interface imem_boot_loader_if;
    import imem_boot_loader_pkg::*;

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_ready;

    modport master (output rx_valid, output rx_data, input  rx_ready);
    modport slave  (input  rx_valid, input  rx_data, output rx_ready);

endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs little-endian data bytes into words, keeps the running XOR and
// pulses word_ready_o the cycle after each word's fourth byte.
module boot_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              last_byte_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o,
    output logic [BYTE_W-1:0] xor_o
);

    localparam int unsigned ACC_W = WORD_W - BYTE_W;

    logic [1:0]        cnt_q,   cnt_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic [WORD_W-1:0] word_q,  word_d;
    logic              ready_q, ready_d;
    logic [BYTE_W-1:0] xor_q,   xor_d;

    // New bytes enter at the top so byte k ends up in bits [8k+7:8k].
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        word_d  = word_q;
        ready_d = 1'b0;
        xor_d   = xor_q;
        if (clear_i) begin
            cnt_d = 2'd0;
            acc_d = '0;
            xor_d = '0;
        end else if (byte_en_i) begin
            xor_d = xor_q ^ byte_i;
            if (cnt_q == 2'd3) begin
                word_d  = {byte_i, acc_q};
                ready_d = 1'b1;
                cnt_d   = 2'd0;
                acc_d   = '0;
            end else begin
                acc_d = {byte_i, acc_q[ACC_W-1:BYTE_W]};
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            acc_q   <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
            xor_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            ready_q <= ready_d;
            xor_q   <= xor_d;
        end
    end

    assign last_byte_o  = (cnt_q == 2'd3);
    assign word_o       = word_q;
    assign word_ready_o = ready_q;
    assign xor_o        = xor_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed image into the instruction ROM and gates core fetch until
// the image checksum verifies.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned       XLEN      = 32,
    parameter int unsigned       ROM_SIZE  = 8192,
    parameter logic [BYTE_W-1:0] MAGIC     = BOOT_MAGIC,
    parameter int unsigned       BASE_ADDR = 0,
    parameter bit                BOOT_LOAD = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_boot_loader_if.slave    rx,
    input  logic                 load_req,
    input  logic                 core_ren,
    input  logic [XLEN-1:0]      core_addr0,
    input  logic [XLEN-1:0]      core_addr1,
    output logic                 imem_ren,
    output logic [XLEN-1:0]      imem_addr0,
    output logic [XLEN-1:0]      imem_addr1,
    output logic                 prog_en,
    output logic [XLEN-1:0]      prog_addr,
    output logic [XLEN-1:0]      prog_data,
    output logic                 core_hold,
    output logic                 load_done,
    output logic                 load_err,
    output logic [COUNT_W-1:0]   words_loaded
);

    localparam int unsigned CAP_WORDS = ROM_SIZE / BYTES_PER_WORD;
    localparam boot_state_t RST_STATE = BOOT_LOAD ? ST_SYNC : ST_RUN;

    boot_state_t        state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] word_idx_q, word_idx_d;
    logic [COUNT_W-1:0] words_loaded_q, words_loaded_d;
    logic [XLEN-1:0]    prog_addr_q, prog_addr_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               rx_ready_q, rx_ready_d;
    logic               hold_q, hold_d;

    logic               accept_c;
    logic               clear_c;
    logic               data_byte_c;
    logic [COUNT_W-1:0] hdr_count_c;
    logic               asm_last;
    logic [WORD_W-1:0]  asm_word;
    logic               asm_ready;
    logic [BYTE_W-1:0]  asm_xor;

    assign accept_c    = rx.rx_valid & rx_ready_q;
    assign hdr_count_c = {rx.rx_data, count_q[BYTE_W-1:0]};

    boot_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear_c),
        .byte_en_i    (data_byte_c),
        .byte_i       (rx.rx_data),
        .last_byte_o  (asm_last),
        .word_o       (asm_word),
        .word_ready_o (asm_ready),
        .xor_o        (asm_xor)
    );

    // Frame parser: next state, counters and sticky status flags.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        word_idx_d     = word_idx_q;
        words_loaded_d = asm_ready ? COUNT_W'(words_loaded_q + 16'd1) : words_loaded_q;
        prog_addr_d    = prog_addr_q;
        done_d         = done_q;
        err_d          = err_q;
        clear_c        = 1'b0;
        data_byte_c    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (accept_c && rx.rx_data == MAGIC) state_d = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (accept_c) begin
                    count_d = COUNT_W'(rx.rx_data);
                    state_d = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (accept_c) begin
                    count_d = hdr_count_c;
                    if (32'(hdr_count_c) > CAP_WORDS) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else if (hdr_count_c == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept_c) begin
                    data_byte_c = 1'b1;
                    if (asm_last) begin
                        prog_addr_d = XLEN'(BASE_ADDR) + (XLEN'(word_idx_q) << 2);
                        word_idx_d  = COUNT_W'(word_idx_q + 16'd1);
                        if (COUNT_W'(word_idx_q + 16'd1) == count_q) state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept_c) begin
                    if (rx.rx_data == asm_xor) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RUN, ST_ERROR: begin
                if (load_req) begin
                    state_d        = ST_SYNC;
                    clear_c        = 1'b1;
                    count_d        = '0;
                    word_idx_d     = '0;
                    words_loaded_d = '0;
                    done_d         = 1'b0;
                    err_d          = 1'b0;
                end
            end
            default: state_d = RST_STATE;
        endcase
        rx_ready_d = (state_d != ST_RUN) && (state_d != ST_ERROR);
        hold_d     = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RST_STATE;
            count_q        <= '0;
            word_idx_q     <= '0;
            words_loaded_q <= '0;
            prog_addr_q    <= '0;
            done_q         <= !BOOT_LOAD;
            err_q          <= 1'b0;
            rx_ready_q     <= BOOT_LOAD;
            hold_q         <= BOOT_LOAD;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            word_idx_q     <= word_idx_d;
            words_loaded_q <= words_loaded_d;
            prog_addr_q    <= prog_addr_d;
            done_q         <= done_d;
            err_q          <= err_d;
            rx_ready_q     <= rx_ready_d;
            hold_q         <= hold_d;
        end
    end

    // Fetch only reaches the ROM in RUN, so it can never collide with prog_en.
    assign imem_ren     = core_ren & ~hold_q;
    assign imem_addr0   = core_addr0;
    assign imem_addr1   = core_addr1;
    assign rx.rx_ready  = rx_ready_q;
    assign prog_en      = asm_ready;
    assign prog_addr    = prog_addr_q;
    assign prog_data    = XLEN'(asm_word);
    assign core_hold    = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frame table plus hand-written
// reset-mid-load sequence, ROM writes checked against a scoreboard queue.
module tb_imem_boot_loader;

    typedef struct {
        logic [127:0] bytes;
        int           len;
        int           hdr;
        logic         done;
        logic         err;
        logic [15:0]  wl;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        load_req;
    logic        core_ren;
    logic [31:0] core_addr0, core_addr1;
    logic        imem_ren;
    logic [31:0] imem_addr0, imem_addr1;
    logic        prog_en;
    logic [31:0] prog_addr, prog_data;
    logic        core_hold, load_done, load_err;
    logic [15:0] words_loaded;

    imem_boot_loader_if rx_if ();

    imem_boot_loader dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx_if),
        .load_req     (load_req),
        .core_ren     (core_ren),
        .core_addr0   (core_addr0),
        .core_addr1   (core_addr1),
        .imem_ren     (imem_ren),
        .imem_addr0   (imem_addr0),
        .imem_addr1   (imem_addr1),
        .prog_en      (prog_en),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[5];
    wr_t  sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] getb(input logic [127:0] by, input int k);
        return by[8*(15-k) +: 8];
    endfunction

    task automatic set_vec(input int i, input logic [127:0] by, input int len, input int hdr,
                           input logic d, input logic e, input logic [15:0] wl);
        vecs[i].bytes = by;
        vecs[i].len   = len;
        vecs[i].hdr   = hdr;
        vecs[i].done  = d;
        vecs[i].err   = e;
        vecs[i].wl    = wl;
    endtask

    // Every ROM write must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b0 && prog_en === 1'b1) begin
            chk("prog_fetch_overlap", {31'd0, imem_ren}, 32'd0);
            if (sb.size() == 0) begin
                chk("prog_unexpected_sb_size", 32'(sb.size()), 32'd1);
            end else begin
                wr_t w;
                w = sb.pop_front();
                chk("prog_addr", prog_addr, w.addr);
                chk("prog_data", prog_data, w.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = b;
        while (rx_if.rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rx_if.rx_ready !== 1'b1) chk("rx_ready_timeout", {31'd0, rx_if.rx_ready}, 32'd1);
        else @(posedge clk);
        #1 rx_if.rx_valid = 1'b0;
    endtask

    task automatic push_expected(input vec_t v);
        int n;
        int base;
        n = int'({getb(v.bytes, v.hdr + 2), getb(v.bytes, v.hdr + 1)});
        if (n >= 1 && n <= 2048) begin
            for (int w = 0; w < n; w++) begin
                wr_t e;
                base   = v.hdr + 3 + 4 * w;
                e.addr = 32'(4 * w);
                e.data = {getb(v.bytes, base + 3), getb(v.bytes, base + 2),
                          getb(v.bytes, base + 1), getb(v.bytes, base)};
                sb.push_back(e);
            end
        end
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        push_expected(v);
        for (int k = 0; k < v.len; k++) send_byte(getb(v.bytes, k));
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_load_done", i), {31'd0, load_done}, {31'd0, v.done});
        chk($sformatf("v%0d_load_err", i), {31'd0, load_err}, {31'd0, v.err});
        chk($sformatf("v%0d_words_loaded", i), {16'd0, words_loaded}, {16'd0, v.wl});
        chk($sformatf("v%0d_core_hold", i), {31'd0, core_hold}, {31'd0, !v.done});
        chk($sformatf("v%0d_rx_ready", i), {31'd0, rx_if.rx_ready}, 32'd0);
        chk($sformatf("v%0d_imem_ren", i), {31'd0, imem_ren}, {31'd0, v.done});
        chk($sformatf("v%0d_sb_drained", i), 32'(sb.size()), 32'd0);
    endtask

    task automatic do_load_req(input string tag);
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk({tag, "_req_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_req_err"}, {31'd0, load_err}, 32'd0);
        chk({tag, "_req_wl"}, {16'd0, words_loaded}, 32'd0);
        chk({tag, "_req_rx_ready"}, {31'd0, rx_if.rx_ready}, 32'd1);
        chk({tag, "_req_hold"}, {31'd0, core_hold}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_if.rx_ready}, 32'd1);
        chk({tag, "_core_hold"}, {31'd0, core_hold}, 32'd1);
        chk({tag, "_imem_ren"}, {31'd0, imem_ren}, 32'd0);
        chk({tag, "_prog_en"}, {31'd0, prog_en}, 32'd0);
        chk({tag, "_prog_addr"}, prog_addr, 32'd0);
        chk({tag, "_prog_data"}, prog_data, 32'd0);
        chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
        chk({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        load_req       = 1'b0;
        core_ren       = 1'b1;
        core_addr0     = 32'h0000_1000;
        core_addr1     = 32'h0000_1004;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;

        set_vec(0, 128'hA5_02_00_0A_00_01_20_FF_FF_FF_FF_2B_00_00_00_00, 12, 0, 1'b1, 1'b0, 16'd2);
        set_vec(1, 128'hA5_02_00_0A_00_01_20_FF_FF_FF_FF_00_00_00_00_00, 12, 0, 1'b0, 1'b1, 16'd2);
        set_vec(2, 128'hA5_01_08_00_00_00_00_00_00_00_00_00_00_00_00_00,  3, 0, 1'b0, 1'b1, 16'd0);
        set_vec(3, 128'h00_13_A5_00_00_00_00_00_00_00_00_00_00_00_00_00,  6, 2, 1'b1, 1'b0, 16'd0);
        set_vec(4, 128'hA5_01_00_78_56_34_12_08_00_00_00_00_00_00_00_00,  8, 0, 1'b1, 1'b0, 16'd1);

        repeat (3) @(negedge clk);
        chk_reset_vals("in_reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_reset");
        chk("addr0_passthru", imem_addr0, core_addr0);
        chk("addr1_passthru", imem_addr1, core_addr1);

        for (int i = 0; i < 5; i++) begin
            apply_vec(i);
            if (i == 0) begin
                for (int k = 0; k < 3; k++) begin
                    core_addr0 = $urandom;
                    core_addr1 = $urandom;
                    core_ren   = k[0];
                    #1;
                    chk("run_addr0", imem_addr0, core_addr0);
                    chk("run_addr1", imem_addr1, core_addr1);
                    chk("run_ren", {31'd0, imem_ren}, {31'd0, core_ren});
                end
                core_ren = 1'b1;
            end
            do_load_req($sformatf("v%0d", i));
        end

        // Reset after five data bytes: word 0 already written, rest abandoned.
        sb.push_back('{addr: 32'h0, data: 32'h2001_000A});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h0A);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'hFF);
        @(negedge clk);
        chk("midload_wl_before_reset", {16'd0, words_loaded}, 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_vals("midload_reset");
        chk("midload_sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        apply_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
